// File: rtl/add_multicycle_if.sv
// -----------------------------------------------------------------------------
// add_multicycle_if
//   Bundles the START/BUSY/DONE handshake, the operands and the result flags
//   of the multi-cycle adder/subtractor.
//
//   Parameter:
//     WIDTH  operand/result width in bits
//
//   Signals:
//     start  request, sampled by the adder only in its IDLE or DONE state
//     sub    0: in1+in2, 1: in1-in2 (sampled with start)
//     in1    operand A (sampled with start)
//     in2    operand B (sampled with start)
//     busy   high while chunks are being processed
//     done   one-cycle pulse, res/cf/z are new in this cycle
//     res    result, held until the next completion
//     cf     carry out (subtract: 1 = no borrow)
//     z      1 when res == 0
//     v, n   signed overflow / sign of res, present only when the macro
//            ADD_OVF_FLAGS_EN is defined
//
//   Modports:
//     master  the controller issuing operations
//     slave   the adder itself
// -----------------------------------------------------------------------------
interface add_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             z;
`ifdef ADD_OVF_FLAGS_EN
    logic             v;
    logic             n;

    modport master (
        output start, sub, in1, in2,
        input  busy, done, res, cf, z, v, n
    );

    modport slave (
        input  start, sub, in1, in2,
        output busy, done, res, cf, z, v, n
    );
`else
    modport master (
        output start, sub, in1, in2,
        input  busy, done, res, cf, z
    );

    modport slave (
        input  start, sub, in1, in2,
        output busy, done, res, cf, z
    );
`endif
endinterface

// File: rtl/add_multicycle.sv
// -----------------------------------------------------------------------------
// add_multicycle
//   Parametrised multi-cycle adder/subtractor. Each accepted operation is
//   processed CHUNK bits per clock with a registered carry; the full result and
//   its flags are latched only on the final chunk, so partial sums never reach
//   the outputs. A DONE cycle may accept the next START, giving one operation
//   every NCYC+1 cycles.
//
//   Parameters:
//     WIDTH  operand/result width (>= 2)
//     CHUNK  bits added per cycle; must divide WIDTH
//
//   Ports:
//     clk_i  clock, all logic on the rising edge
//     rst_i  synchronous reset, active-high, priority over everything
//     bus    add_multicycle_if.slave (start/sub/in1/in2 in,
//            busy/done/res/cf/z out)
//
//   Optional feature (macro ADD_OVF_FLAGS_EN):
//     when defined, the interface carries v (signed overflow = carry into MSB
//     xor carry out of MSB) and n (res MSB), both registered with res.
// -----------------------------------------------------------------------------
module add_multicycle #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    add_multicycle_if.slave bus
);

    localparam int NCYC = WIDTH / CHUNK;
    localparam int IDXW = (NCYC > 1) ? $clog2(NCYC) : 1;

    // Reject configurations whose chunking does not tile the operand exactly.
    generate
        if ((WIDTH < 2) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("add_multicycle: CHUNK must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cf_q, cf_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ADD_OVF_FLAGS_EN
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             msb_cin_s;
`endif

    logic [31:0]      shamt_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_add_s;
    logic [CHUNK-1:0] s_chunk_s;
    logic [WIDTH-1:0] chunk_mask_s;
    logic [WIDTH-1:0] s_wide_s;
    logic [WIDTH-1:0] sum_upd_s;
    logic             last_s;
    logic             capture_s;

    // Chunk slice: select the current CHUNK bits by shifting, add with carry,
    // and merge the partial sum back into its slot of the sum register.
    always_comb begin
        shamt_s      = 32'(idx_q) * 32'(CHUNK);
        a_chunk_s    = CHUNK'(a_q >> shamt_s);
        b_chunk_s    = CHUNK'(b_q >> shamt_s);
        chunk_add_s  = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, carry_q};
        s_chunk_s    = chunk_add_s[CHUNK-1:0];
        chunk_mask_s = WIDTH'({CHUNK{1'b1}});
        s_wide_s     = WIDTH'(s_chunk_s);
        sum_upd_s    = (sum_q & ~(chunk_mask_s << shamt_s)) | (s_wide_s << shamt_s);
        last_s       = (idx_q == IDXW'(NCYC - 1));
    end

`ifdef ADD_OVF_FLAGS_EN
    // Carry into the MSB recovered from the top bit of the last chunk:
    // s = a ^ b ^ cin for a single bit position.
    always_comb begin
        msb_cin_s = a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1] ^ s_chunk_s[CHUNK-1];
    end
`endif

    // FSM next state, operand capture, chunk accumulation and completion latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        res_d     = res_q;
        cf_d      = cf_q;
        z_d       = z_q;
        capture_s = 1'b0;
`ifdef ADD_OVF_FLAGS_EN
        v_d       = v_q;
        n_d       = n_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    capture_s = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // START is deliberately not looked at here.
                sum_d   = sum_upd_s;
                carry_d = chunk_add_s[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (last_s) begin
                    state_d = ST_DONE;
                    res_d   = sum_upd_s;
                    cf_d    = chunk_add_s[CHUNK];
                    z_d     = (sum_upd_s == {WIDTH{1'b0}});
`ifdef ADD_OVF_FLAGS_EN
                    v_d     = msb_cin_s ^ chunk_add_s[CHUNK];
                    n_d     = sum_upd_s[WIDTH-1];
`endif
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    capture_s = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Subtraction is A + ~B + 1: invert B once here and seed the carry.
        if (capture_s) begin
            a_d     = bus.in1;
            b_d     = bus.sub ? ~bus.in2 : bus.in2;
            carry_d = bus.sub;
            idx_d   = {IDXW{1'b0}};
            sum_d   = {WIDTH{1'b0}};
        end else begin
            a_d     = a_d;
        end

        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            cf_q    <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADD_OVF_FLAGS_EN
            v_q     <= 1'b0;
            n_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            cf_q    <= cf_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADD_OVF_FLAGS_EN
            v_q     <= v_d;
            n_q     <= n_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.cf   = cf_q;
    assign bus.z    = z_q;
`ifdef ADD_OVF_FLAGS_EN
    assign bus.v    = v_q;
    assign bus.n    = n_q;
`endif

endmodule

// File: tb/tb_add_multicycle.sv
// -----------------------------------------------------------------------------
// tb_add_multicycle
//   Self-checking bench for add_multicycle. dut_a uses WIDTH=16/CHUNK=4,
//   dut_b uses WIDTH=16/CHUNK=16. Expected results are pushed to a scoreboard
//   queue when an operation is issued and popped when DONE is seen. The v/n
//   flags are compared only when ADD_OVF_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_add_multicycle;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_multicycle_if #(.WIDTH(W)) ifa ();
    add_multicycle_if #(.WIDTH(W)) ifb ();

    add_multicycle #(.WIDTH(W), .CHUNK(4)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifa)
    );

    add_multicycle #(.WIDTH(W), .CHUNK(16)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifb)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        cf;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

`ifdef ADD_OVF_FLAGS_EN
    localparam exp_t CMP_MASK = {16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1};
`else
    localparam exp_t CMP_MASK = {16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(input logic [15:0] r, input logic cf, input logic z,
                                input logic v, input logic n);
        exp_t e;
        e.res = r;
        e.cf  = cf;
        e.z   = z;
        e.v   = v;
        e.n   = n;
        return e;
    endfunction

    // Reference: plain 17-bit arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        logic [16:0] full;
        logic [15:0] bb;
        exp_t        e;
        bb    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
        e.res = full[15:0];
        e.cf  = full[16];
        e.z   = (full[15:0] == 16'd0);
        e.n   = full[15];
        if (sub) e.v = (a[15] != b[15]) && (full[15] != a[15]);
        else     e.v = (a[15] == b[15]) && (full[15] != a[15]);
        return e;
    endfunction

    function automatic exp_t observe(input bit sel);
        exp_t o;
        o = '0;
        if (sel) begin
            o.res = ifb.res; o.cf = ifb.cf; o.z = ifb.z;
`ifdef ADD_OVF_FLAGS_EN
            o.v = ifb.v; o.n = ifb.n;
`endif
        end else begin
            o.res = ifa.res; o.cf = ifa.cf; o.z = ifa.z;
`ifdef ADD_OVF_FLAGS_EN
            o.v = ifa.v; o.n = ifa.n;
`endif
        end
        return o;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("res=%h cf=%b z=%b v=%b n=%b", e.res, e.cf, e.z, e.v, e.n);
    endfunction

    // Drive one request at the current negedge, record its expectation, and
    // return at the negedge of the first BUSY cycle.
    task automatic issue(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input exp_t e);
        if (sel) begin
            ifb.start = 1'b1; ifb.sub = sub; ifb.in1 = a; ifb.in2 = b;
        end else begin
            ifa.start = 1'b1; ifa.sub = sub; ifa.in1 = a; ifa.in2 = b;
        end
        sb_q.push_back(e);
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    // Advance negedge by negedge until DONE is seen or the budget runs out.
    task automatic wait_done(input bit sel, input int bound, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && (cyc < bound)) begin
            @(negedge clk);
            cyc++;
            seen = sel ? ifb.done : ifa.done;
        end
    endtask

    task automatic test_reset();
        exp_t got;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.sub = 1'b0; ifa.in1 = 16'd0; ifa.in2 = 16'd0;
        ifb.start = 1'b0; ifb.sub = 1'b0; ifb.in1 = 16'd0; ifb.in2 = 16'd0;
        repeat (3) @(negedge clk);
        got = observe(1'b0);
        checks++;
        if ((got & CMP_MASK) !== 20'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: got %s busy=%b done=%b, expected all zero", fmt(got), ifa.busy, ifa.done);
        end
        got = observe(1'b1);
        checks++;
        if ((got & CMP_MASK) !== 20'd0 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: got %s busy=%b done=%b, expected all zero", fmt(got), ifb.busy, ifb.done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timing_t1();
        exp_t got, e;
        int   bad;
        issue(1'b0, 16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t1_busy_window: %0d of 4 cycles wrong, expected busy=1 done=0 in all", bad);
        end
        checks++;
        if (ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_done_cycle: got busy=%b done=%b, expected busy=0 done=1", ifa.busy, ifa.done);
        end
        e = sb_q.pop_front();
        got = observe(1'b0);
        checks++;
        if ((got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL t1_result: got %s, expected %s", fmt(got), fmt(e));
        end
        @(negedge clk);
        got = observe(1'b0);
        checks++;
        if (ifa.done !== 1'b0 || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL t1_hold: got done=%b %s, expected done=0 %s", ifa.done, fmt(got), fmt(e));
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vs [5];
        exp_t        ve [5];
        exp_t        got, e;
        bit          seen;
        int          cyc;
        va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 1'b0; ve[0] = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        va[1] = 16'h0005; vb[1] = 16'h0007; vs[1] = 1'b1; ve[1] = mk(16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        va[2] = 16'h0007; vb[2] = 16'h0007; vs[2] = 1'b1; ve[2] = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        va[3] = 16'h7FFF; vb[3] = 16'h0001; vs[3] = 1'b0; ve[3] = mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
        va[4] = 16'h8000; vb[4] = 16'h0001; vs[4] = 1'b1; ve[4] = mk(16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, va[i], vb[i], vs[i], ve[i]);
            wait_done(1'b0, 10, seen, cyc);
            e = sb_q.pop_front();
            got = observe(1'b0);
            checks++;
            if (!seen || (got & CMP_MASK) !== (e & CMP_MASK)) begin
                errors++;
                $display("FAIL vector_%0d: done_seen=%b got %s, expected %s", i, seen, fmt(got), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        exp_t got, e;
        bit   seen;
        int   cyc;
        issue(1'b0, 16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        ifa.start = 1'b1; ifa.sub = 1'b1; ifa.in1 = 16'hAAAA; ifa.in2 = 16'h5555;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_done(1'b0, 10, seen, cyc);
        e = sb_q.pop_front();
        got = observe(1'b0);
        checks++;
        if (!seen || cyc != 2 || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL start_ignored: done_seen=%b wait=%0d got %s, expected wait=2 %s", seen, cyc, fmt(got), fmt(e));
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
                errors++;
                $display("FAIL start_ignored_idle: got busy=%b done=%b, expected 0 0", ifa.busy, ifa.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        bit   seen;
        int   cyc;
        issue(1'b0, 16'h0003, 16'h0004, 1'b0, mk(16'h0007, 1'b0, 1'b0, 1'b0, 1'b0));
        wait_done(1'b0, 10, seen, cyc);
        e = sb_q.pop_front();
        got = observe(1'b0);
        checks++;
        if (!seen || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL b2b_first: done_seen=%b got %s, expected %s", seen, fmt(got), fmt(e));
        end
        issue(1'b0, 16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0, 1'b0));
        checks++;
        if (ifa.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, expected 1", ifa.busy);
        end
        wait_done(1'b0, 10, seen, cyc);
        e = sb_q.pop_front();
        got = observe(1'b0);
        checks++;
        if (!seen || (cyc + 1) != 5 || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL b2b_second: done_seen=%b gap=%0d got %s, expected gap=5 %s", seen, cyc + 1, fmt(got), fmt(e));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        exp_t got, e;
        bit   seen;
        int   cyc;
        issue(1'b0, 16'hFFFF, 16'h0002, 1'b0, mk(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0));
        wait_done(1'b0, 10, seen, cyc);
        e = sb_q.pop_front();
        got = observe(1'b0);
        checks++;
        if (!seen || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL pre_reset_op: done_seen=%b got %s, expected %s", seen, fmt(got), fmt(e));
        end
        issue(1'b0, 16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = observe(1'b0);
        checks++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || (got & CMP_MASK) !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid_op: got busy=%b done=%b %s, expected all zero", ifa.busy, ifa.done, fmt(got));
        end
        rst = 1'b0;
        sb_q.delete();
        wait_done(1'b0, 12, seen, cyc);
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done: got done after %0d cycles, expected none", cyc);
        end
    endtask

    task automatic test_full_chunk();
        exp_t got, e;
        bit   seen;
        int   cyc;
        issue(1'b1, 16'h1234, 16'h4321, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0));
        checks++;
        if (ifb.busy !== 1'b1 || ifb.done !== 1'b0) begin
            errors++;
            $display("FAIL chunk16_busy: got busy=%b done=%b, expected 1 0", ifb.busy, ifb.done);
        end
        wait_done(1'b1, 10, seen, cyc);
        e = sb_q.pop_front();
        got = observe(1'b1);
        checks++;
        if (!seen || (cyc + 1) != 2 || (got & CMP_MASK) !== (e & CMP_MASK)) begin
            errors++;
            $display("FAIL chunk16_result: done_seen=%b latency=%0d got %s, expected latency=2 %s", seen, cyc + 1, fmt(got), fmt(e));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        s;
        bit          sel, seen;
        int          cyc;
        exp_t        got, e;
        for (int i = 0; i < 12; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            s   = 1'($urandom_range(0, 1));
            sel = 1'(i % 2);
            issue(sel, a, b, s, model(a, b, s));
            wait_done(sel, 10, seen, cyc);
            e = sb_q.pop_front();
            got = observe(sel);
            checks++;
            if (!seen || (got & CMP_MASK) !== (e & CMP_MASK)) begin
                errors++;
                $display("FAIL random_%0d: dut=%0d a=%h b=%h sub=%b done_seen=%b got %s, expected %s",
                         i, sel, a, b, s, seen, fmt(got), fmt(e));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_timing_t1();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_full_chunk();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
